slow_clk_monitor: RTL and testbench
===================================

// Module: slow_clk_monitor
// PURPOSE
//  Receive-side companion to the slow clock divider. Takes a slow, asynchronous
//  clock-like waveform (divider output or an external slow source) into the
//  clk_in domain: synchronises it, emits rise/fall pulses, measures its
//  half-period in clk_in cycles and flags a stalled source. Used for on-board
//  checking of divider output and for clean single-cycle enables from slow edges.
// PARAMETERS
//  CNT_W    28           width of interval counter and half_period
//  TIMEOUT  250000000    cycles with no edge before stalled is set (< 2**CNT_W)
// PORTS
//  clk_in        in   1      fast system clock, all logic on posedge
//  rst_n         in   1      asynchronous active-low reset
//  sig_in        in   1      slow asynchronous waveform to monitor
//  rise_pulse    out  1      1-cycle pulse per synchronised rising edge
//  fall_pulse    out  1      1-cycle pulse per synchronised falling edge
//  half_period   out  CNT_W  last measured edge-to-edge interval, in cycles
//  period_valid  out  1      1-cycle pulse when half_period updates
//  stalled       out  1      high while no edge has arrived for TIMEOUT cycles
//  edge_count    out  16     number of edges detected since reset, wraps
// BEHAVIOUR
//  - Reset (rst_n=0, async): sync regs, history reg, counter, half_period,
//    edge_count = 0; all pulse outputs and stalled = 0; state = WAIT_EDGE.
//  - Sync chain: s1<=sig_in, s2<=s1, s3<=s2. edge = s2^s3. rise = s2&~s3.
//  - Pulses are registered. If sig_in changes before posedge k (sampled into s1
//    at k), rise_pulse/fall_pulse is high from posedge k+2 to k+3 (3-edge latency).
//  - Interval counter: cleared to 0 in the edge cycle, else +1, saturating at
//    TIMEOUT. On an edge, measured value = counter+1 = cycles since prior edge.
//  - FSM:
//    WAIT_EDGE : no reference edge yet. On edge -> MEASURE, clear counter,
//                no period_valid.
//    MEASURE   : on edge -> stay, half_period <= counter+1, period_valid=1 next
//                cycle (aligned with rise/fall pulse). If counter reaches
//                TIMEOUT-1 with no edge -> STALL.
//    STALL     : stalled=1, counter held at TIMEOUT. On edge -> MEASURE,
//                stalled<=0, counter cleared, no period_valid (interval
//                unbounded, discarded).
//  - stalled is set at the posedge where counter would reach TIMEOUT, i.e.
//    exactly TIMEOUT cycles after the last edge's detect cycle.
//  - half_period holds its last value across STALL and WAIT_EDGE; never cleared
//    except by reset.
//  - edge_count +1 per detected edge in any state; 16'hFFFF wraps to 0.
//  - Adjacent edges (1-cycle high/low on s2) are both detected; second gives
//    half_period = 1. Edges only via the sync chain; sig_in never feeds logic raw.
//  - Reset mid-measurement discards the interval; first edge after reset gives
//    no period_valid.
//  - rise_pulse and fall_pulse are never high in the same cycle.
// TESTING (sim with TIMEOUT=100, CNT_W=28)
//  1. Assert rst_n=0 with sig_in toggling -> all outputs 0, stays 0 while low.
//  2. sig_in toggles every 10 cycles -> no period_valid on 1st edge; from 2nd
//     edge on, period_valid with half_period=10; edge_count increments per edge.
//  3. sig_in 0->1 just before posedge k -> rise_pulse high exactly at k+2 only;
//     1->0 later -> fall_pulse similarly; never both high.
//  4. After edges, hold sig_in 100 cycles -> stalled rises exactly 100 cycles
//     after last detect; next edge clears stalled, no period_valid; following
//     edge 7 cycles later -> half_period=7.
//  5. sig_in high for one clk_in cycle -> rise_pulse then fall_pulse on
//     consecutive cycles, second gives half_period=1, edge_count +2.
//  6. Pull rst_n low for 1 cycle mid-interval (counter ~50) -> all cleared;
//     next edge no period_valid; edge 20 cycles later -> half_period=20.

Source files
------------

// File: rtl/slow_clk_monitor.sv
// slow_clk_monitor
//   Brings a slow, asynchronous clock-like waveform into the clk_in domain.
//   Synchronises it, emits single-cycle rise/fall pulses, measures the
//   edge-to-edge interval in clk_in cycles and flags a source that has stopped
//   toggling.
//
// Ports
//   clk_in        in   1      fast system clock, all logic on posedge
//   rst_n         in   1      asynchronous active-low reset
//   sig_in        in   1      slow asynchronous waveform to monitor
//   rise_pulse    out  1      1-cycle pulse per synchronised rising edge
//   fall_pulse    out  1      1-cycle pulse per synchronised falling edge
//   half_period   out  CNT_W  last measured edge-to-edge interval, in cycles
//   period_valid  out  1      1-cycle pulse when half_period updates
//   stalled       out  1      high while no edge has arrived for TIMEOUT cycles
//   edge_count    out  16     edges detected since reset, wraps
module slow_clk_monitor #(
    parameter int unsigned CNT_W   = 28,
    parameter int unsigned TIMEOUT = 250000000
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             stalled,
    output logic [15:0]      edge_count
);

    localparam int unsigned EC_W = 16;

    localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_M1_C = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        MEASURE   = 2'd1,
        STALL     = 2'd2
    } state_e;

    state_e state_q, state_d;

    // s1/s2 form the metastability chain; s3 is the edge-history register
    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_period_q, half_period_d;
    logic [EC_W-1:0]  edge_count_q, edge_count_d;
    logic             rise_pulse_q, rise_pulse_d;
    logic             fall_pulse_q, fall_pulse_d;
    logic             period_valid_q, period_valid_d;
    logic             stalled_q, stalled_d;

    logic edge_c;
    logic cnt_inc_c;

    assign edge_c = s2_q ^ s3_q;

    // Free-running interval count, saturating at TIMEOUT
    assign cnt_inc_c = (cnt_q < TIMEOUT_C);

    // Next-state and output logic
    always_comb begin
        state_d        = state_q;
        s1_d           = sig_in;
        s2_d           = s1_q;
        s3_d           = s2_q;
        cnt_d          = cnt_inc_c ? (cnt_q + ONE_C) : TIMEOUT_C;
        half_period_d  = half_period_q;
        period_valid_d = 1'b0;
        rise_pulse_d   = s2_q & ~s3_q;
        fall_pulse_d   = ~s2_q & s3_q;
        edge_count_d   = edge_c ? (edge_count_q + EC_W'(1)) : edge_count_q;

        unique case (state_q)
            WAIT_EDGE: begin
                // First edge only establishes a reference point
                if (edge_c) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                end
            end
            MEASURE: begin
                if (edge_c) begin
                    cnt_d          = '0;
                    half_period_d  = cnt_q + ONE_C;
                    period_valid_d = 1'b1;
                end else if (cnt_q >= TIMEOUT_M1_C) begin
                    state_d = STALL;
                    cnt_d   = TIMEOUT_C;
                end
            end
            STALL: begin
                cnt_d = TIMEOUT_C;
                // Interval across a stall is unbounded, so it is not reported
                if (edge_c) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = WAIT_EDGE;
                cnt_d   = '0;
            end
        endcase

        stalled_d = (state_d == STALL);
    end

    // State and datapath registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= WAIT_EDGE;
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
            cnt_q          <= '0;
            half_period_q  <= '0;
            edge_count_q   <= '0;
            rise_pulse_q   <= 1'b0;
            fall_pulse_q   <= 1'b0;
            period_valid_q <= 1'b0;
            stalled_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            s3_q           <= s3_d;
            cnt_q          <= cnt_d;
            half_period_q  <= half_period_d;
            edge_count_q   <= edge_count_d;
            rise_pulse_q   <= rise_pulse_d;
            fall_pulse_q   <= fall_pulse_d;
            period_valid_q <= period_valid_d;
            stalled_q      <= stalled_d;
        end
    end

    assign rise_pulse   = rise_pulse_q;
    assign fall_pulse   = fall_pulse_q;
    assign half_period  = half_period_q;
    assign period_valid = period_valid_q;
    assign stalled      = stalled_q;
    assign edge_count   = edge_count_q;

endmodule

// File: tb/tb_slow_clk_monitor.sv
// tb_slow_clk_monitor
//   Directed and randomized stimulus for slow_clk_monitor. A reference model
//   built from sample history and edge timestamps predicts every output on
//   every clock; directed checks pin down the documented scenarios.
module tb_slow_clk_monitor;

    localparam int unsigned CNT_W   = 28;
    localparam int unsigned TIMEOUT = 100;

    logic             clk_in = 1'b0;
    logic             rst_n  = 1'b0;
    logic             sig_in = 1'b0;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             stalled;
    logic [15:0]      edge_count;

    slow_clk_monitor #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .sig_in       (sig_in),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .half_period  (half_period),
        .period_valid (period_valid),
        .stalled      (stalled),
        .edge_count   (edge_count)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;
    int pv_seen  = 0;

    // Reference model: samples taken since reset, time of last reported edge
    bit               samp_q[$];
    int               t;
    bit               have_ref;
    int               last_p;
    logic             exp_rise, exp_fall, exp_pv, exp_stalled;
    logic [CNT_W-1:0] exp_hp;
    logic [15:0]      exp_ec;

    function automatic bit samp(input int k);
        if (k < 1 || k > samp_q.size()) return 1'b0;
        return samp_q[k-1];
    endfunction

    task automatic model_reset();
        samp_q.delete();
        t           = 0;
        have_ref    = 1'b0;
        last_p      = 0;
        exp_rise    = 1'b0;
        exp_fall    = 1'b0;
        exp_pv      = 1'b0;
        exp_stalled = 1'b0;
        exp_hp      = '0;
        exp_ec      = '0;
    endtask

    // An input sampled at posedge k shows up as a pulse at posedge k+2
    task automatic model_step(input bit v);
        bit a, b;
        t++;
        samp_q.push_back(v);
        a = samp(t - 2);
        b = samp(t - 3);
        exp_rise = a & ~b;
        exp_fall = ~a & b;
        exp_pv   = 1'b0;
        if (a != b) begin
            exp_ec = exp_ec + 16'd1;
            if (have_ref && (t - last_p) <= int'(TIMEOUT)) begin
                exp_pv = 1'b1;
                exp_hp = CNT_W'(t - last_p);
            end
            have_ref    = 1'b1;
            last_p      = t;
            exp_stalled = 1'b0;
        end else begin
            exp_stalled = have_ref && ((t - last_p) >= int'(TIMEOUT));
        end
    endtask

    task automatic check_all();
        checks++;
        assert (rise_pulse === exp_rise) else begin
            failures++;
            $error("FAIL rise_pulse t=%0d got=%0b exp=%0b", t, rise_pulse, exp_rise);
        end
        checks++;
        assert (fall_pulse === exp_fall) else begin
            failures++;
            $error("FAIL fall_pulse t=%0d got=%0b exp=%0b", t, fall_pulse, exp_fall);
        end
        checks++;
        assert (period_valid === exp_pv) else begin
            failures++;
            $error("FAIL period_valid t=%0d got=%0b exp=%0b", t, period_valid, exp_pv);
        end
        checks++;
        assert (half_period === exp_hp) else begin
            failures++;
            $error("FAIL half_period t=%0d got=%0d exp=%0d", t, half_period, exp_hp);
        end
        checks++;
        assert (stalled === exp_stalled) else begin
            failures++;
            $error("FAIL stalled t=%0d got=%0b exp=%0b", t, stalled, exp_stalled);
        end
        checks++;
        assert (edge_count === exp_ec) else begin
            failures++;
            $error("FAIL edge_count t=%0d got=%0d exp=%0d", t, edge_count, exp_ec);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock: drive the level, let the edge happen, compare just after it
    task automatic cycle(input bit v);
        sig_in = v;
        @(posedge clk_in);
        if (rst_n) model_step(v);
        #1;
        if (period_valid === 1'b1) pv_seen++;
        check_all();
    endtask

    task automatic drive_for(input bit v, input int n);
        for (int i = 0; i < n; i++) cycle(v);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk_in);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        bit          v;
        logic [15:0] ec0;

        // Reset held with sig_in toggling: everything stays zero
        model_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) cycle(bit'(i % 2));
        chk("rst_edge_count", 32'(edge_count), 32'd0);
        chk("rst_half_period", 32'(half_period), 32'd0);
        rst_n = 1'b1;

        // Toggle every 10 cycles: 6 edges, first one unreported
        drive_for(1'b0, 5);
        pv_seen = 0;
        for (int i = 1; i <= 6; i++) drive_for(bit'(i % 2), 10);
        chk("t2_pv_count", 32'(pv_seen), 32'd5);
        chk("t2_half_period", 32'(half_period), 32'd10);
        chk("t2_edge_count", 32'(edge_count), 32'd6);

        // Rise latency: pulse exactly at the third posedge after the change
        drive_for(1'b1, 1);
        chk("t3_rise_k", 32'(rise_pulse), 32'd0);
        drive_for(1'b1, 1);
        chk("t3_rise_k1", 32'(rise_pulse), 32'd0);
        drive_for(1'b1, 1);
        chk("t3_rise_k2", 32'(rise_pulse), 32'd1);
        chk("t3_fall_k2", 32'(fall_pulse), 32'd0);
        chk("t3_hp_rise", 32'(half_period), 32'd10);
        drive_for(1'b1, 1);
        chk("t3_rise_k3", 32'(rise_pulse), 32'd0);
        drive_for(1'b1, 6);
        drive_for(1'b0, 2);
        chk("t3_fall_k1", 32'(fall_pulse), 32'd0);
        drive_for(1'b0, 1);
        chk("t3_fall_k2", 32'(fall_pulse), 32'd1);
        chk("t3_rise_at_fall", 32'(rise_pulse), 32'd0);
        chk("t3_hp_fall", 32'(half_period), 32'd10);

        // Stall exactly TIMEOUT cycles after the last edge, then recover
        drive_for(1'b0, 99);
        chk("t4_not_stalled_yet", 32'(stalled), 32'd0);
        drive_for(1'b0, 1);
        chk("t4_stalled", 32'(stalled), 32'd1);
        drive_for(1'b0, 20);
        chk("t4_stalled_hold", 32'(stalled), 32'd1);
        chk("t4_hp_held", 32'(half_period), 32'd10);
        drive_for(1'b1, 2);
        chk("t4_still_stalled", 32'(stalled), 32'd1);
        drive_for(1'b1, 1);
        chk("t4_stall_cleared", 32'(stalled), 32'd0);
        chk("t4_no_pv", 32'(period_valid), 32'd0);
        drive_for(1'b1, 4);
        drive_for(1'b0, 2);
        drive_for(1'b0, 1);
        chk("t4_pv_after", 32'(period_valid), 32'd1);
        chk("t4_hp7", 32'(half_period), 32'd7);

        // Single-cycle high pulse: back-to-back edges
        drive_for(1'b0, 5);
        ec0 = exp_ec;
        drive_for(1'b1, 1);
        drive_for(1'b0, 2);
        chk("t5_rise", 32'(rise_pulse), 32'd1);
        chk("t5_no_fall", 32'(fall_pulse), 32'd0);
        drive_for(1'b0, 1);
        chk("t5_fall", 32'(fall_pulse), 32'd1);
        chk("t5_no_rise", 32'(rise_pulse), 32'd0);
        chk("t5_pv", 32'(period_valid), 32'd1);
        chk("t5_hp1", 32'(half_period), 32'd1);
        chk("t5_ec_plus2", 32'(edge_count), 32'(ec0 + 16'd2));

        // Reset mid-interval with sig_in high
        drive_for(1'b1, 1);
        drive_for(1'b1, 52);
        pulse_reset();
        chk("t6_hp_cleared", 32'(half_period), 32'd0);
        chk("t6_ec_cleared", 32'(edge_count), 32'd0);
        drive_for(1'b1, 2);
        drive_for(1'b1, 1);
        chk("t6_first_rise", 32'(rise_pulse), 32'd1);
        chk("t6_first_no_pv", 32'(period_valid), 32'd0);
        chk("t6_ec1", 32'(edge_count), 32'd1);
        drive_for(1'b1, 17);
        drive_for(1'b0, 2);
        drive_for(1'b0, 1);
        chk("t6_pv", 32'(period_valid), 32'd1);
        chk("t6_hp20", 32'(half_period), 32'd20);

        // Random level durations, including some that stall
        v = 1'b0;
        for (int i = 0; i < 40; i++) begin
            v = ~v;
            drive_for(v, int'($urandom_range(1, 130)));
        end

        // Toggle every cycle long enough for edge_count to wrap
        for (int i = 0; i < 65540; i++) begin
            v = ~v;
            cycle(v);
        end
        chk("wrap_edge_count", 32'(edge_count), 32'(exp_ec));
        chk("wrap_hp1", 32'(half_period), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
